// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP datapath blocks: data RAM region
// bases, activation format and the argmax scan state encoding.
package mlp_pkg;

  localparam int ACT_W = 8;

  // Data RAM regions: input vector, hidden-layer activations, output layer.
  localparam logic [9:0] DATA_IN_BASE  = 10'h000;
  localparam logic [9:0] DATA_A_BASE   = 10'h100;
  localparam logic [9:0] DATA_OUT_BASE = 10'h200;

  // Most negative signed activation; the neutral value for a max search.
  localparam logic [ACT_W-1:0] ACT_MIN = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } argmax_state_t;

  // Winner minus runner-up. As a 9-bit signed difference this is always in
  // 0..255 because best >= second, so the low 8 bits of the wrapped 8-bit
  // subtraction are already the exact unsigned result.
  function automatic logic [ACT_W-1:0] act_margin(input logic [ACT_W-1:0] best,
                                                  input logic [ACT_W-1:0] second);
    return best - second;
  endfunction

endpackage

// File: rtl/mlp_argmax_if.sv
// Data RAM read port B and result handshake between mlp_argmax and its
// surroundings. master = the argmax block, slave = RAM + result consumer.
interface mlp_argmax_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              res_valid;
  logic              res_ready;
  logic [IDX_W-1:0]  class_idx;
  logic [DATA_W-1:0] max_val;
  logic [7:0]        margin;

  modport master (
    output rd_en, rd_addr, res_valid, class_idx, max_val, margin,
    input  rd_data, res_ready
  );

  modport slave (
    input  rd_en, rd_addr, res_valid, class_idx, max_val, margin,
    output rd_data, res_ready
  );
endinterface

// File: rtl/mlp_top2_tracker.sv
// Running top-two tracker for signed activations: keeps the best value, its
// index and the runner-up. Strict greater-than keeps the lowest index on a
// tie, while an equal value still lands in the runner-up slot (margin 0).
module mlp_top2_tracker
  import mlp_pkg::*;
#(
  parameter int DATA_W = ACT_W,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_val,
  input  logic [IDX_W-1:0]  smp_idx,
  output logic [DATA_W-1:0] best,
  output logic [DATA_W-1:0] second,
  output logic [IDX_W-1:0]  best_idx
);

  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  // Clear at scan start, otherwise fold each valid sample into the top two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best     <= MIN_VAL;
      second   <= MIN_VAL;
      best_idx <= '0;
    end else if (clear) begin
      best     <= MIN_VAL;
      second   <= MIN_VAL;
      best_idx <= '0;
    end else if (smp_valid) begin
      if ($signed(smp_val) > $signed(best)) begin
        second   <= best;
        best     <= smp_val;
        best_idx <= smp_idx;
      end else if ($signed(smp_val) > $signed(second)) begin
        second <= smp_val;
      end
    end
  end

endmodule

// File: rtl/mlp_argmax.sv
// Output-layer argmax: on start, streams H activations out of the data RAM
// output region, tracks the top two, and presents winner index, value and
// confidence margin over a valid/ready handshake.
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int              ADDR_W    = 10,
  parameter int              DATA_W    = 8,
  parameter int              IDX_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DATA_OUT_BASE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] H,
  output logic             busy,
  output logic             empty_err,
  mlp_argmax_if.master     bus
);

  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  argmax_state_t     state;
  logic [IDX_W-1:0]  h_r;
  logic [IDX_W-1:0]  cnt;
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_r;
  // Index tag travelling alongside the RAM latency: rd_en/cnt form the first
  // stage, tag_* the second, which lines up with rd_data.
  logic              tag_v;
  logic [IDX_W-1:0]  tag_idx;
  logic              busy_r;
  logic              res_valid_r;
  logic [IDX_W-1:0]  class_idx_r;
  logic [DATA_W-1:0] max_val_r;
  logic [7:0]        margin_r;
  logic              empty_err_r;

  logic              clear;
  logic [DATA_W-1:0] best;
  logic [DATA_W-1:0] second;
  logic [IDX_W-1:0]  best_idx;

  assign clear = (state == ST_IDLE) && start;

  mlp_top2_tracker #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .smp_valid (tag_v),
    .smp_val   (bus.rd_data),
    .smp_idx   (tag_idx),
    .best      (best),
    .second    (second),
    .best_idx  (best_idx)
  );

  // Scan sequencer, tag pipeline and registered result/handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      h_r         <= '0;
      cnt         <= '0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= BASE_ADDR;
      tag_v       <= 1'b0;
      tag_idx     <= '0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      class_idx_r <= '0;
      max_val_r   <= MIN_VAL;
      margin_r    <= 8'd0;
      empty_err_r <= 1'b0;
    end else begin
      tag_v   <= rd_en_r;
      tag_idx <= cnt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            h_r       <= H;
            cnt       <= '0;
            rd_addr_r <= BASE_ADDR;
            busy_r    <= 1'b1;
            if (H == '0) begin
              // Nothing to scan: flag the error and skip straight to output.
              rd_en_r     <= 1'b0;
              class_idx_r <= '1;
              max_val_r   <= MIN_VAL;
              margin_r    <= 8'd0;
              empty_err_r <= 1'b1;
              state       <= ST_OUT;
            end else begin
              rd_en_r <= 1'b1;
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (cnt == h_r - IDX_ONE) begin
            rd_en_r <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            cnt       <= cnt + IDX_ONE;
            rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          // The last sample is folded into the tracker on this same edge.
          if (tag_v && (tag_idx == h_r - IDX_ONE)) begin
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (!res_valid_r) begin
            res_valid_r <= 1'b1;
            if (!empty_err_r) begin
              class_idx_r <= best_idx;
              max_val_r   <= best;
              margin_r    <= act_margin(best, second);
            end
          end else if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            empty_err_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign empty_err     = empty_err_r;
  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.res_valid = res_valid_r;
  assign bus.class_idx = class_idx_r;
  assign bus.max_val   = max_val_r;
  assign bus.margin    = margin_r;

endmodule

// File: tb/tb_mlp_argmax.sv
// Bench for mlp_argmax: RAM model with one-cycle read latency, a
// transaction-level reference (result appears a fixed number of edges after
// an accepted start, computed by a two-pass max/runner-up search) checked on
// every cycle, plus hand-computed expectations for each directed scan.
module tb_mlp_argmax;

  localparam int BASE = 512;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] H = 8'd0;
  logic       busy;
  logic       empty_err;

  mlp_argmax_if #(.ADDR_W(10), .DATA_W(8), .IDX_W(8)) bus ();

  mlp_argmax dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .H         (H),
    .busy      (busy),
    .empty_err (empty_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];

  // Data RAM port B: registered read.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result for a scan of h entries: max with lowest index, then
  // runner-up as the largest of all other positions (floor -128).
  function automatic logic [23:0] ref_scan(input int h);
    int best, second, bi, v;
    best = -128; second = -128; bi = 0;
    for (int i = 0; i < h; i++) begin
      v = int'($signed(mem[BASE + i]));
      if (v > best) begin best = v; bi = i; end
    end
    for (int i = 0; i < h; i++) begin
      v = int'($signed(mem[BASE + i]));
      if (i != bi && v > second) second = v;
    end
    return {8'(bi), 8'(best), 8'(best - second)};
  endfunction

  // Reference model state (reset values as initialisers).
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_idx = 8'd0;
  logic [7:0] m_max = 8'h80;
  logic [7:0] m_mg = 8'd0;
  int         m_age = 0;
  int         m_h = 0;

  // Reference model: accepted start, fixed latency, handoff.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
      m_idx <= 8'd0; m_max <= 8'h80; m_mg <= 8'd0; m_age <= 0; m_h <= 0;
    end else if (m_valid && bus.res_ready) begin
      m_valid <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
    end else if (m_busy && !m_valid) begin
      m_age <= m_age + 1;
      if (m_age + 1 == ((m_h == 0) ? 1 : m_h + 2)) begin
        m_valid <= 1'b1;
        if (m_h != 0) {m_idx, m_max, m_mg} <= ref_scan(m_h);
      end
    end else if (!m_busy && start) begin
      m_busy <= 1'b1; m_age <= 0; m_h <= int'(H);
      if (H == 8'd0) begin
        m_err <= 1'b1; m_idx <= 8'hFF; m_max <= 8'h80; m_mg <= 8'd0;
      end
    end
  end

  // Per-cycle compare against the reference model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
      chk("empty_err", 32'(empty_err), 32'(m_err));
      chk("class_idx", 32'(bus.class_idx), 32'(m_idx));
      chk("max_val", 32'(bus.max_val), 32'(m_max));
      chk("margin", 32'(bus.margin), 32'(m_mg));
      chk("rd_en", 32'(bus.rd_en), 32'(m_busy && !m_valid && (m_age < m_h)));
      if (m_busy && !m_valid && (m_age < m_h))
        chk("rd_addr", 32'(bus.rd_addr), 32'(BASE + m_age));
    end
  end

  int         lat;
  logic [9:0] addrs [$];

  task automatic set_val(input int i, input int v);
    mem[BASE + i] = 8'(v);
  endtask

  // Start a scan and wait (bounded) for res_valid; optionally pulse a
  // second start (with a different H) while busy.
  task automatic run_scan(input int h, input bit ready, input int extra_at);
    addrs.delete();
    bus.res_ready = ready;
    start = 1'b1; H = 8'(h);
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (!bus.res_valid && lat < 400) begin
      if (bus.rd_en) addrs.push_back(bus.rd_addr);
      if (lat == extra_at) begin start = 1'b1; H = 8'd3; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!bus.res_valid) chk("valid_timeout", 32'(lat), 32'd0);
  endtask

  task automatic accept(input bit also_start);
    bus.res_ready = 1'b1; start = also_start;
    @(negedge clk);
    bus.res_ready = 1'b0; start = 1'b0;
  endtask

  initial begin
    bus.res_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1; chk_on = 1'b1;
    @(negedge clk);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'h200);
    chk("rst_max_val", 32'(bus.max_val), 32'h80);

    // H=4 {10,-5,40,7}
    set_val(0, 10); set_val(1, -5); set_val(2, 40); set_val(3, 7);
    run_scan(4, 1'b1, -1);
    chk("h4_lat", 32'(lat), 32'd6);
    chk("h4_idx", 32'(bus.class_idx), 32'd2);
    chk("h4_max", 32'(bus.max_val), 32'd40);
    chk("h4_margin", 32'(bus.margin), 32'd30);
    chk("h4_naddr", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < addrs.size() && i < 4; i++)
      chk("h4_addr_seq", 32'(addrs[i]), 32'(32'h200 + i));
    accept(1'b0);

    // H=3 tie {25,25,3}
    set_val(0, 25); set_val(1, 25); set_val(2, 3);
    run_scan(3, 1'b1, -1);
    chk("tie_idx", 32'(bus.class_idx), 32'd0);
    chk("tie_max", 32'(bus.max_val), 32'd25);
    chk("tie_margin", 32'(bus.margin), 32'd0);
    accept(1'b0);

    // H=1 {-20}
    set_val(0, -20);
    run_scan(1, 1'b1, -1);
    chk("h1_lat", 32'(lat), 32'd3);
    chk("h1_max", 32'(bus.max_val), 32'hEC);
    chk("h1_margin", 32'(bus.margin), 32'd108);
    accept(1'b0);

    // H=0 -> empty
    run_scan(0, 1'b1, -1);
    chk("h0_lat", 32'(lat), 32'd1);
    chk("h0_idx", 32'(bus.class_idx), 32'hFF);
    chk("h0_err", 32'(empty_err), 32'd1);
    accept(1'b0);
    chk("h0_err_clr", 32'(empty_err), 32'd0);

    // H=26 all -128 except idx 25 = 127; held result, ignored starts
    for (int i = 0; i < 26; i++) set_val(i, -128);
    set_val(25, 127);
    run_scan(26, 1'b0, 5);
    chk("h26_lat", 32'(lat), 32'd28);
    repeat (10) @(negedge clk);
    chk("h26_hold_valid", 32'(bus.res_valid), 32'd1);
    chk("h26_idx", 32'(bus.class_idx), 32'd25);
    chk("h26_max", 32'(bus.max_val), 32'h7F);
    chk("h26_margin", 32'(bus.margin), 32'd255);
    accept(1'b1);
    chk("h26_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    chk("h26_start_ignored", 32'(busy), 32'd0);

    // Reset mid-READ, then a clean scan of i-10 with idx 13 = 100
    for (int i = 0; i < 26; i++) set_val(i, i - 10);
    set_val(13, 100);
    start = 1'b1; H = 8'd26;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
    chk("abort_rd_addr", 32'(bus.rd_addr), 32'h200);
    chk("abort_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_scan(26, 1'b1, -1);
    chk("post_rst_lat", 32'(lat), 32'd28);
    chk("post_rst_idx", 32'(bus.class_idx), 32'd13);
    chk("post_rst_max", 32'(bus.max_val), 32'd100);
    chk("post_rst_margin", 32'(bus.margin), 32'd85);
    accept(1'b0);

    // Back-to-back H=11, no carry-over of the previous best (100)
    set_val(0, 5); set_val(1, -3); set_val(2, 60); set_val(3, 12);
    set_val(4, -100); set_val(5, 0); set_val(6, 59); set_val(7, 8);
    set_val(8, 61); set_val(9, 1); set_val(10, -1);
    run_scan(11, 1'b1, -1);
    chk("b2b_lat", 32'(lat), 32'd13);
    chk("b2b_idx", 32'(bus.class_idx), 32'd8);
    chk("b2b_max", 32'(bus.max_val), 32'd61);
    chk("b2b_margin", 32'(bus.margin), 32'd1);
    accept(1'b0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mlp_argmax.md
Name: mlp_argmax

Overview:
- Classification stage directly downstream of mlp_core.
- When the core reports the output layer complete, this block scans the H signed 8-bit output activations in the data RAM output region (read port B of the dual-port data RAM).
- Reports the winning class index, its activation, and a confidence margin (winner minus runner-up) over a valid/ready handshake.

Parameters:
- ADDR_W, 10, data RAM address width.
- DATA_W, 8, activation width, signed two's complement.
- IDX_W, 8, class index width; matches the core's H width.
- BASE_ADDR, 10'h200, first address of the output-layer region.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin a scan (driven from core status done).
- H  in  8  number of output neurons to scan; sampled at start.
- rd_en  out  1  data RAM read enable.
- rd_addr  out  ADDR_W  data RAM read address (port B).
- rd_data  in  DATA_W  data RAM read data, 1-cycle registered latency.
- busy  out  1  high from accepted start until result is handed off.
- res_valid  out  1  result registers valid.
- res_ready  in  1  consumer accepts the result.
- class_idx  out  IDX_W  index (0-based) of the maximum activation.
- max_val  out  DATA_W  signed maximum activation.
- margin  out  8  unsigned max_val minus runner-up value.
- empty_err  out  1  scan requested with H==0.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - busy, rd_en, res_valid, empty_err = 0; rd_addr = BASE_ADDR; class_idx = 0; max_val = 8'h80; margin = 0.
- States: IDLE, READ, DRAIN, OUT.
- IDLE:
  - start=1 at edge E0: latch H into H_r.
  - Clear best = -128, second = -128, best_idx = 0.
  - rd_addr <= BASE_ADDR, rd_en <= 1, busy <= 1, go to READ.
  - If H==0: go directly to OUT with class_idx = 8'hFF, max_val = 8'h80, margin = 0, empty_err = 1.
- READ:
  - Issue one address per cycle: BASE_ADDR .. BASE_ADDR+H_r-1, using an 8-bit issue counter.
  - After the last address, rd_en <= 0 and go to DRAIN.
- Read data path:
  - Data for address index i is present on rd_data during the cycle after it is addressed.
  - It is sampled at edge E(i+2) together with a delayed index tag (2-stage valid/index shift register).
- Compare, per sampled value v with index i:
  - If v > best: second <= best, best <= v, best_idx <= i.
  - Else if v > second: second <= v.
  - Strict greater-than, so ties keep the lowest index.
  - The second-place update also covers v == best: a tie gives margin 0.
- DRAIN: wait until the last sample is compared (edge E(H+1)), then go to OUT.
- OUT:
  - Results register at E(H+2): res_valid = 1, class_idx = best_idx, max_val = best.
  - margin = best - second, computed as a 9-bit signed difference; always 0..255, so the low 8 bits are exact.
  - H==1: runner-up stays -128, so margin = max + 128.
- Result latency: start edge to res_valid high = H+2 cycles (28 for H=26).
- Handshake:
  - Results hold stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready at an edge: res_valid <= 0, busy <= 0, empty_err <= 0, return to IDLE.
  - Outputs keep their last values after handoff.
- start while busy=1 is ignored, including in the same cycle as the handoff edge. A new scan needs start with busy=0.
- H above 255 is not representable. Address wrap past 10'h3FF is not checked; BASE_ADDR+H must stay ≤ 2^ADDR_W.
- Reset mid-scan aborts immediately: outputs return to reset values and no partial result is produced.

Decomposition:
- Shared package mlp_pkg:
  - Region base constants DATA_IN_BASE = 10'h000, DATA_A_BASE = 10'h100, DATA_OUT_BASE = 10'h200.
  - Activation width and signed min constant ACT_MIN = 8'h80.
  - State enum typedef.
- One natural sub-module: mlp_top2_tracker, holding best/second/best_idx registers and the compare/update logic, with clear and sample-valid inputs.
- Address sequencer and FSM stay in mlp_argmax.

Test Plan:
- H=4, memory[0x200..0x203] = {10, -5, 40, 7}, start, res_ready=1 -> res_valid at +6 cycles; class_idx=2, max_val=40, margin=30; rd_addr sequence 0x200..0x203.
- H=3, values {25, 25, 3} -> class_idx=0, max_val=25, margin=0 (tie keeps lowest index).
- H=1, value -20 -> class_idx=0, max_val=-20, margin=108; H=0 -> class_idx=8'hFF, empty_err=1, res_valid after 1 cycle.
- H=26, all -128 except index 25 = 127; res_ready held 0 for 10 cycles -> class_idx=25, margin=255; outputs stable until res_ready; busy drops on the accept edge; second start mid-scan ignored.
- Reset asserted low mid-READ (H=26, cycle 10) -> outputs at reset values immediately; state IDLE; a subsequent start runs a clean scan with correct result.
- Back-to-back: accept result, pulse start next cycle with H=11 -> second result correct, no stale best/second carry-over.
